// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - instruction fields and flags in, datapath selects and strobes out
interface multicycle_control_fsm_if;
  logic [6:0] i_op;
  logic [2:0] i_funct3;
  logic       i_funct7b5;
  logic       i_zero;
  logic       i_lt;
  logic       i_memReady;
  logic       o_pcWrite;
  logic       o_irWrite;
  logic       o_regWrite;
  logic       o_memWrite;
  logic       o_adrSrc;
  logic [1:0] o_aluSrcA;
  logic [1:0] o_aluSrcB;
  logic [1:0] o_resultSrc;
  logic [2:0] o_immSrc;
  logic [3:0] o_aluControl;
  logic       o_illegal;
  logic [3:0] o_state;

  modport master (
    output i_op, i_funct3, i_funct7b5, i_zero, i_lt, i_memReady,
    input  o_pcWrite, o_irWrite, o_regWrite, o_memWrite, o_adrSrc,
    input  o_aluSrcA, o_aluSrcB, o_resultSrc, o_immSrc, o_aluControl,
    input  o_illegal, o_state
  );

  modport slave (
    input  i_op, i_funct3, i_funct7b5, i_zero, i_lt, i_memReady,
    output o_pcWrite, o_irWrite, o_regWrite, o_memWrite, o_adrSrc,
    output o_aluSrcA, o_aluSrcB, o_resultSrc, o_immSrc, o_aluControl,
    output o_illegal, o_state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore control FSM for the multi-cycle RV32I core
module multicycle_control_fsm #(
  parameter bit EXTENDED_ISA  = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_srst,
  multicycle_control_fsm_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRWB   = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       mem_ready;
  logic       taken;
  logic       pc_write, ir_write, reg_write, mem_write;
  logic       adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_control;

  assign mem_ready = MEM_HANDSHAKE ? bus.i_memReady : 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    case (bus.i_funct3)
      3'b001:  taken = ~bus.i_zero;
      3'b100:  taken = bus.i_lt;
      3'b101:  taken = ~bus.i_lt;
      default: taken = bus.i_zero;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    imm_src     = 3'b000;
    alu_control = 4'b0000;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b010;
        case (bus.i_op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          // funct3 bit 1 clear selects exactly BEQ/BNE/BLT/BGE
          OP_B:         state_d = bus.i_funct3[1] ? S_TRAP : S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = EXTENDED_ISA ? S_JALR : S_TRAP;
          OP_LUI:       state_d = EXTENDED_ISA ? S_LUI : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (bus.i_op == OP_SW) ? 3'b001 : 3'b000;
        state_d   = (bus.i_op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        imm_src   = 3'b001;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = {bus.i_funct7b5, bus.i_funct3};
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = {1'b0, bus.i_funct3};
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = 4'b1000;
        pc_write    = taken;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        imm_src   = 3'b011;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JALRWB;
      end
      S_JALRWB: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src   = 3'b100;
        state_d   = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // TRAP is absorbing, so the sticky flag only needs to see entry into it
  assign illegal_d = illegal_q | (state_d == S_TRAP);

  assign bus.o_pcWrite    = pc_write  & ~i_srst;
  assign bus.o_irWrite    = ir_write  & ~i_srst;
  assign bus.o_regWrite   = reg_write & ~i_srst;
  assign bus.o_memWrite   = mem_write & ~i_srst;
  assign bus.o_adrSrc     = adr_src;
  assign bus.o_aluSrcA    = alu_src_a;
  assign bus.o_aluSrcB    = alu_src_b;
  assign bus.o_resultSrc  = result_src;
  assign bus.o_immSrc     = imm_src;
  assign bus.o_aluControl = alu_control;
  assign bus.o_illegal    = illegal_q;
  assign bus.o_state      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm, both parameter corners
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0] state;
    logic       pc;
    logic       ir;
    logic       rg;
    logic       mw;
    logic       adr;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ill;
  } outs_t;

  typedef struct packed {
    logic  sel;
    outs_t e;
  } rec_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  multicycle_control_fsm_if ifa ();
  multicycle_control_fsm_if ifb ();

  multicycle_control_fsm #(.EXTENDED_ISA(1'b1), .MEM_HANDSHAKE(1'b1)) dut_a (
    .i_clk (clk),
    .i_srst(rst_a),
    .bus   (ifa)
  );

  multicycle_control_fsm #(.EXTENDED_ISA(1'b0), .MEM_HANDSHAKE(1'b0)) dut_b (
    .i_clk (clk),
    .i_srst(rst_b),
    .bus   (ifb)
  );

  rec_t       q[$];
  int         checks = 0;
  int         passed = 0;
  logic       act;
  logic       ill_m;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7, cur_z, cur_lt;
  int         pth[5];
  int         plen;

  function automatic outs_t exp_out(input logic [3:0] st, input logic rdy, input logic rs_in);
    outs_t o;
    logic  tk;
    o       = '0;
    o.state = st;
    o.ill   = ill_m;
    case (cur_f3)
      3'b000:  tk = cur_z;
      3'b001:  tk = !cur_z;
      3'b100:  tk = cur_lt;
      default: tk = !cur_lt;
    endcase
    case (st)
      4'd0:  begin o.sb = 2'b10; o.rs = 2'b10; o.ir = rdy; o.pc = rdy; end
      4'd1:  begin o.sa = 2'b01; o.sb = 2'b01; o.imm = 3'b010; end
      4'd2:  begin o.sa = 2'b10; o.sb = 2'b01; o.imm = (cur_op == OP_SW) ? 3'b001 : 3'b000; end
      4'd3:  o.adr = 1'b1;
      4'd4:  begin o.rs = 2'b01; o.rg = 1'b1; end
      4'd5:  begin o.adr = 1'b1; o.imm = 3'b001; o.mw = 1'b1; end
      4'd6:  begin o.sa = 2'b10; o.alu = {cur_f7, cur_f3}; end
      4'd7:  begin o.sa = 2'b10; o.sb = 2'b01; o.alu = {1'b0, cur_f3}; end
      4'd8:  o.rg = 1'b1;
      4'd9:  begin o.sa = 2'b10; o.alu = 4'b1000; o.pc = tk; end
      4'd10: begin o.sa = 2'b01; o.sb = 2'b10; o.imm = 3'b011; o.pc = 1'b1; end
      4'd11: begin o.sa = 2'b10; o.sb = 2'b01; end
      4'd12: begin o.sa = 2'b01; o.sb = 2'b10; o.pc = 1'b1; end
      4'd13: begin o.sa = 2'b11; o.sb = 2'b01; o.imm = 3'b100; end
      default: ;
    endcase
    if (rs_in) begin
      o.pc = 1'b0; o.ir = 1'b0; o.rg = 1'b0; o.mw = 1'b0;
    end
    return o;
  endfunction

  function automatic outs_t sample(input logic sel);
    outs_t o;
    if (sel)
      o = {ifb.o_state, ifb.o_pcWrite, ifb.o_irWrite, ifb.o_regWrite, ifb.o_memWrite, ifb.o_adrSrc,
           ifb.o_aluSrcA, ifb.o_aluSrcB, ifb.o_resultSrc, ifb.o_immSrc, ifb.o_aluControl, ifb.o_illegal};
    else
      o = {ifa.o_state, ifa.o_pcWrite, ifa.o_irWrite, ifa.o_regWrite, ifa.o_memWrite, ifa.o_adrSrc,
           ifa.o_aluSrcA, ifa.o_aluSrcB, ifa.o_resultSrc, ifa.o_immSrc, ifa.o_aluControl, ifa.o_illegal};
    return o;
  endfunction

  // Instruction-level schedule: the state sequence after FETCH, from the per-class CPI table
  task automatic build_path(input logic [6:0] op, input logic [2:0] f3, input bit ext);
    plen = 2;
    pth[0] = 1;
    case (op)
      OP_LW:   begin pth[1] = 2; pth[2] = 3; pth[3] = 4; plen = 4; end
      OP_SW:   begin pth[1] = 2; pth[2] = 5; plen = 3; end
      OP_R:    begin pth[1] = 6; pth[2] = 8; plen = 3; end
      OP_I:    begin pth[1] = 7; pth[2] = 8; plen = 3; end
      OP_B:    pth[1] = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101) ? 9 : 15;
      OP_JAL:  begin pth[1] = 10; pth[2] = 8; plen = 3; end
      OP_JALR: if (ext) begin pth[1] = 11; pth[2] = 12; pth[3] = 8; plen = 4; end else pth[1] = 15;
      OP_LUI:  if (ext) begin pth[1] = 13; pth[2] = 8; plen = 3; end else pth[1] = 15;
      default: pth[1] = 15;
    endcase
  endtask

  task automatic drive_cycle(input int st, input logic rdy, input logic rs_in);
    rec_t r;
    @(posedge clk);
    #1;
    ifa.i_op = cur_op; ifa.i_funct3 = cur_f3; ifa.i_funct7b5 = cur_f7;
    ifa.i_zero = cur_z; ifa.i_lt = cur_lt; ifa.i_memReady = rdy;
    ifb.i_op = cur_op; ifb.i_funct3 = cur_f3; ifb.i_funct7b5 = cur_f7;
    ifb.i_zero = cur_z; ifb.i_lt = cur_lt; ifb.i_memReady = rdy;
    rst_a = act ? 1'b1 : rs_in;
    rst_b = act ? rs_in : 1'b1;
    r.sel = act;
    r.e   = exp_out(4'(st), act ? 1'b1 : rdy, rs_in);
    q.push_back(r);
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input logic lt, input int fw, input int mw, input bit abort);
    bit hs;
    int s;
    hs = (act == 1'b0);
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z; cur_lt = lt;
    build_path(op, f3, act == 1'b0);
    if (hs) begin
      repeat (fw) drive_cycle(0, 1'b0, 1'b0);
      drive_cycle(0, 1'b1, 1'b0);
    end else begin
      drive_cycle(0, 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < plen; i++) begin
      s = pth[i];
      if (s == 15) begin
        ill_m = 1'b1;
        repeat (21) drive_cycle(15, 1'($urandom_range(0, 1)), 1'b0);
        drive_cycle(15, 1'b1, 1'b1);
        ill_m = 1'b0;
        return;
      end else if (s == 5 && abort) begin
        drive_cycle(5, 1'b0, 1'b1);
        return;
      end else if ((s == 3 || s == 5) && hs) begin
        repeat (mw) drive_cycle(s, 1'b0, 1'b0);
        drive_cycle(s, 1'b1, 1'b0);
      end else begin
        drive_cycle(s, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
  endtask

  task automatic run_random(input int n);
    logic [6:0] ops[8];
    logic [6:0] op;
    int         k;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL, OP_JALR, OP_LUI};
    for (int i = 0; i < n; i++) begin
      k  = $urandom_range(0, 9);
      op = (k < 8) ? ops[k] : 7'($urandom);
      run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    rec_t  r;
    outs_t got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        r   = q.pop_front();
        got = sample(r.sel);
        checks++;
        if (got !== r.e)
          $display("FAIL cycle_outputs dut=%0d state got=%0d exp=%0d bundle got=%h exp=%h",
                   r.sel, got.state, r.e.state, got, r.e);
        else
          passed++;
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; act = 1'b0; ill_m = 1'b0;
    cur_op = '0; cur_f3 = '0; cur_f7 = 1'b0; cur_z = 1'b0; cur_lt = 1'b0;
    ifa.i_op = '0; ifa.i_funct3 = '0; ifa.i_funct7b5 = 1'b0; ifa.i_zero = 1'b0; ifa.i_lt = 1'b0; ifa.i_memReady = 1'b0;
    ifb.i_op = '0; ifb.i_funct3 = '0; ifb.i_funct7b5 = 1'b0; ifb.i_zero = 1'b0; ifb.i_lt = 1'b0; ifb.i_memReady = 1'b0;

    run_instr(OP_R,    3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_LW,   3'b010, 1'b0, 1'b0, 1'b0, 2, 1, 1'b0);
    run_instr(OP_B,    3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_B,    3'b101, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    run_instr(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_LUI,  3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_R,    3'b000, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0);
    run_instr(OP_I,    3'b000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_SW,   3'b010, 1'b0, 1'b0, 1'b0, 0, 2, 1'b1);
    run_instr(OP_SW,   3'b010, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0);
    run_instr(OP_B,    3'b010, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_random(60);

    drive_cycle(0, 1'b1, 1'b1);
    act   = 1'b1;
    ill_m = 1'b0;
    run_instr(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_LUI,  3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_LW,   3'b010, 1'b0, 1'b0, 1'b0, 2, 2, 1'b0);
    run_random(60);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0)
      $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Parametrised control unit for the multi-cycle RV32I core: a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles and drives every datapath select and write strobe. Unlike the base decoder it optionally supports JALR and LUI, a variable-latency memory handshake, BNE/BLT/BGE branches and an illegal-instruction trap. It sits between the instruction register fields, ALU flags and memory ready on one side and the datapath muxes and enables on the other.

## Interface
- EXTENDED_ISA, 1, 1 enables the JALR (7'b1100111) and LUI (7'b0110111) decode paths; 0 treats those opcodes as illegal
- MEM_HANDSHAKE, 1, 1 honours i_memReady; 0 treats i_memReady as constant 1
- i_clk  in  1  clock; all state updates on rising edge
- i_srst  in  1  reset, synchronous, active-high
- i_op  in  7  instruction opcode field
- i_funct3  in  3  instruction funct3
- i_funct7b5  in  1  instruction bit 30
- i_zero  in  1  ALU result == 0
- i_lt  in  1  signed RD1 < RD2, valid in BRANCH
- i_memReady  in  1  memory completes the current access this cycle
- o_pcWrite, o_irWrite, o_regWrite, o_memWrite  out  1 each  write strobes
- o_adrSrc  out  1  0 = PC, 1 = ALUOut
- o_aluSrcA  out  2  00 PC, 01 OLD_PC, 10 RD1, 11 ZERO
- o_aluSrcB  out  2  00 RD2, 01 IMM, 10 FOUR
- o_resultSrc  out  2  00 ALUOut, 01 DATA, 10 ALU result
- o_immSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- o_aluControl  out  4  {funct7b5, funct3} codes: ADD 0000, SLT 0010, XOR 0100, OR 0110, AND 0111, SUB 1000
- o_illegal  out  1  sticky trap flag
- o_state  out  4  current state encoding for debug

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALRWB 12, LUI 13, TRAP 15.
- Every output not listed for a state is 0.
- FETCH: adrSrc 0, srcA PC, srcB FOUR, ADD, resultSrc 10. irWrite = pcWrite = memReady. Stays in FETCH until memReady, then goes to DECODE.
- DECODE: srcA OLD_PC, srcB IMM, immSrc B, ADD. Next state by opcode:
  - LW or SW -> MEMADR
  - R-type -> EXECR
  - I-type ALU -> EXECI
  - B-type with funct3 in {000, 001, 100, 101} -> BRANCH
  - JAL -> JAL
  - JALR or LUI -> JALR or LUI when EXTENDED_ISA
  - anything else -> TRAP
- MEMADR: srcA RD1, srcB IMM, ADD. immSrc I for LW, S for SW. Goes to MEMREAD for LW, MEMWRITE for SW.
- MEMREAD: adrSrc 1. Goes to MEMWB on memReady, otherwise holds.
- MEMWB: resultSrc 01, regWrite 1. Goes to FETCH.
- MEMWRITE: adrSrc 1, immSrc S, memWrite 1 held until memReady. Goes to FETCH on memReady.
- EXECR: srcA RD1, srcB RD2, aluControl {funct7b5, funct3}. Goes to ALUWB.
- EXECI: srcA RD1, srcB IMM, immSrc I, aluControl {0, funct3}. funct7b5 is ignored, so there is no SUBI. Goes to ALUWB.
- ALUWB: resultSrc 00, regWrite 1. Goes to FETCH.
- BRANCH: srcA RD1, srcB RD2, SUB, resultSrc 00. pcWrite = taken, where taken is:
  - 000: zero
  - 001: !zero
  - 100: lt
  - 101: !lt
  - Goes to FETCH.
- JAL: srcA OLD_PC, srcB FOUR, ADD, resultSrc 00, immSrc J, pcWrite 1. Goes to ALUWB.
- JALR: srcA RD1, srcB IMM, immSrc I, ADD. Goes to JALRWB. The datapath clears the target LSB.
- JALRWB: srcA OLD_PC, srcB FOUR, ADD, resultSrc 00, pcWrite 1. Goes to ALUWB.
- LUI: srcA ZERO, srcB IMM, immSrc U, ADD. Goes to ALUWB.
- TRAP: all strobes 0, o_illegal 1. Absorbing; only i_srst exits.

## Timing
- Reset: state = FETCH and o_illegal = 0 on the first edge with i_srst high.
- While i_srst is high, pcWrite, irWrite, regWrite and memWrite are forced 0 combinationally.
- Reset asserted mid-instruction aborts it; no strobe fires in that cycle.
- Outputs are combinational from state and the instruction fields; o_illegal is registered.
- Cycles per instruction with zero wait states:
  - LW 5, SW 4, R 4, I 4, JAL 4, LUI 4
  - B 3
  - JALR 5
- Each cycle with memReady low in FETCH, MEMREAD or MEMWRITE adds one cycle. Strobes in those states stay asserted or gated exactly as specified until the ready cycle.
- With MEM_HANDSHAKE = 0, i_memReady is ignored and latencies are fixed.
- o_illegal rises on the edge leaving DECODE into TRAP and stays 1 until reset.

## Test plan
- Reset, then R-type ADD (op 0110011, funct3 000, funct7b5 0) with memReady=1 -> states 0,1,6,8,0. aluControl 0000 in EXECR, regWrite only in ALUWB.
- LW with memReady low for 2 cycles in FETCH and 1 cycle in MEMREAD -> 8 cycles total. irWrite=pcWrite=1 only on the ready FETCH cycle; regWrite with resultSrc 01 in MEMWB.
- BNE: funct3 001 with i_zero=0 gives pcWrite=1 in BRANCH. BGE: funct3 101 with i_lt=1 gives pcWrite=0. Both return to FETCH after 3 cycles.
- JALR with EXTENDED_ISA=1 -> states 0,1,11,12,8. JALR with EXTENDED_ISA=0 -> TRAP, o_illegal=1, and no strobes for 20 further cycles.
- LUI -> in state 13, srcA 11, immSrc 100, aluControl 0000.
- i_srst asserted during MEMWRITE with memReady=0 -> memWrite=0 that cycle, next state FETCH, o_illegal=0.
